// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg: shared function codes and sequencer state encoding
// for the sequential ALU unit and its multiply/divide engine.
package seq_alu_pkg;

  localparam logic [5:0] F_SLL   = 6'd0;
  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_SLT   = 6'd42;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_alu_muldiv.sv
// seq_alu_muldiv: iterative shift-add multiplier (and optional
// restoring divider) owning the HI/LO registers.
// Optional feature macro: SEQ_ALU_DIVU_EN (adds div_start, DIV state).
// Ports: clk, rst (sync, active-high), mul_start/div_start (one-cycle
//   start pulses, only while idle), a/b operands, busy, hi, lo.
module seq_alu_muldiv
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mul_start,
`ifdef SEQ_ALU_DIVU_EN
  input  logic             div_start,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     opnd;
  logic [2*WIDTH-1:0]   acc;

  // Multiply: acc = {partial, multiplier}; add then shift right.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_nxt;

  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};

`ifdef SEQ_ALU_DIVU_EN
  // Divide: acc = {remainder, quotient}; shift left, trial subtract.
  // A zero divisor always "fits", giving all-ones Q and R = dividend.
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH-1:0]     rem_sub;
  logic                 rem_ge;
  logic [2*WIDTH-1:0]   div_nxt;

  assign rem_sh  = acc[2*WIDTH-1:WIDTH-1];
  assign rem_sub = rem_sh[WIDTH-1:0] - opnd;
  assign rem_ge  = rem_sh >= {1'b0, opnd};
  assign div_nxt = {rem_ge ? rem_sub : rem_sh[WIDTH-1:0],
                    acc[WIDTH-2:0], rem_ge};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
      opnd  <= '0;
      acc   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (mul_start) begin
            state <= MUL;
            busy  <= 1'b1;
            opnd  <= a;
            acc   <= {{WIDTH{1'b0}}, b};
          end
`ifdef SEQ_ALU_DIVU_EN
          else if (div_start) begin
            state <= DIV;
            busy  <= 1'b1;
            opnd  <= b;
            acc   <= {{WIDTH{1'b0}}, a};
          end
`endif
        end
        MUL: begin
          acc <= mul_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state    <= IDLE;
            busy     <= 1'b0;
            {hi, lo} <= mul_nxt;
          end
        end
`ifdef SEQ_ALU_DIVU_EN
        DIV: begin
          acc <= div_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            hi    <= div_nxt[2*WIDTH-1:WIDTH];
            lo    <= div_nxt[WIDTH-1:0];
          end
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/seq_alu_unit.sv
// seq_alu_unit: single-issue ALU with one-cycle ops and a sequential
// MULTU (plus DIVU when SEQ_ALU_DIVU_EN is defined) feeding HI/LO.
// Ports: clk, rst (sync, active-high), in_valid/in_ready request
//   handshake, funct, shamt, a, b; out_valid, result, zero, busy.
module seq_alu_unit
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       funct,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             busy
);

  logic             accept;
  logic             is_mul;
  logic             is_long;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] res_d;

  assign in_ready = !busy;
  assign accept   = in_valid && in_ready;
  assign is_mul   = funct == F_MULTU;

`ifdef SEQ_ALU_DIVU_EN
  logic is_div;
  assign is_div  = funct == F_DIVU;
  assign is_long = is_mul || is_div;
`else
  assign is_long = is_mul;
`endif

  seq_alu_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .mul_start(accept && is_mul),
`ifdef SEQ_ALU_DIVU_EN
    .div_start(accept && is_div),
`endif
    .a        (a),
    .b        (b),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

  always_comb begin
    res_d = '0;
    unique case (1'b1)
      funct == F_AND:  res_d = a & b;
      funct == F_OR:   res_d = a | b;
      funct == F_ADD:  res_d = a + b;
      funct == F_SUB:  res_d = a - b;
      funct == F_SLT:
        res_d = {{(WIDTH-1){1'b0}},
                 $signed(a) < $signed(b)};
      funct == F_SLL:  res_d = b << shamt;
      funct == F_MFHI: res_d = hi;
      funct == F_MFLO: res_d = lo;
      default:         res_d = '0;
    endcase
  end

  // Long ops report through HI/LO only, never via out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b1;
    end else begin
      out_valid <= accept && !is_long;
      if (accept && !is_long) begin
        result <= res_d;
        zero   <= res_d == '0;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu_unit.sv
// tb_seq_alu_unit: randomized self-checking bench for seq_alu_unit
// against a plain-arithmetic reference model (32-bit and 16-bit).
module tb_seq_alu_unit;
  import seq_alu_pkg::*;

  localparam int W  = 32;
  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    funct;
  logic [SW-1:0] shamt;
  logic [W-1:0]  a, b;
  logic          out_valid;
  logic [W-1:0]  result;
  logic          zero;
  logic          busy;

  logic          in_valid16;
  logic          in_ready16;
  logic [5:0]    funct16;
  logic [3:0]    shamt16;
  logic [15:0]   a16, b16;
  logic          out_valid16;
  logic [15:0]   result16;
  logic          zero16;
  logic          busy16;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  always #5 clk = ~clk;

  seq_alu_unit u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .shamt(shamt), .a(a), .b(b),
    .out_valid(out_valid), .result(result),
    .zero(zero), .busy(busy)
  );

  seq_alu_unit #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .funct(funct16), .shamt(shamt16), .a(a16), .b(b16),
    .out_valid(out_valid16), .result(result16),
    .zero(zero16), .busy(busy16)
  );

  function automatic bit is_known(input logic [5:0] f);
    return f inside {F_AND, F_OR, F_ADD, F_SUB, F_SLT,
                     F_SLL, F_MULTU, F_MFHI, F_MFLO, F_DIVU};
  endfunction

  function automatic logic [W-1:0] ref_op(
    input logic [5:0] f, input logic [W-1:0] x,
    input logic [W-1:0] y, input int s);
    longint sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (f)
      F_AND:  return x & y;
      F_OR:   return x | y;
      F_ADD:  return W'(64'(x) + 64'(y));
      F_SUB:  return W'(64'(x) + 64'(~y) + 64'd1);
      F_SLT:  return (sx < sy) ? 1 : 0;
      F_SLL:  return W'(64'(y) * (64'd1 << s));
      F_MFHI: return m_hi;
      F_MFLO: return m_lo;
      default: return '0;
    endcase
  endfunction

  task automatic issue(input logic [5:0] f, input logic [W-1:0] x,
                       input logic [W-1:0] y, input int s);
    @(negedge clk);
    funct = f; a = x; b = y; shamt = SW'(s);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic issue16(input logic [5:0] f, input logic [15:0] x,
                         input logic [15:0] y, input int s);
    @(negedge clk);
    funct16 = f; a16 = x; b16 = y; shamt16 = 4'(s);
    in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, in_ready, out_valid, zero} !== 4'b0101) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 0101",
               {busy, in_ready, out_valid, zero});
    end
    n_checks++;
    if (result !== '0) begin
      n_fail++;
      $display("FAIL reset_result: got %h want 0", result);
    end
    n_checks++;
    if ({busy16, in_ready16, out_valid16, zero16, result16}
        !== {4'b0101, 16'h0}) begin
      n_fail++;
      $display("FAIL reset16: got %b %h want 0101 0000",
               {busy16, in_ready16, out_valid16, zero16}, result16);
    end
    m_hi = '0;
    m_lo = '0;
  endtask

  task automatic run_one(input logic [5:0] f, input logic [W-1:0] x,
                         input logic [W-1:0] y, input int s,
                         input string tag);
    logic [W-1:0] exp;
    exp = ref_op(f, x, y, s);
    issue(f, x, y, s);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || result !== exp ||
        zero !== (exp == '0)) begin
      n_fail++;
      $display("FAIL %s f=%0d a=%h b=%h s=%0d: got v=%b r=%h z=%b want v=1 r=%h z=%b",
               tag, f, x, y, s, out_valid, result, zero,
               exp, exp == '0);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || result !== exp ||
        zero !== (exp == '0)) begin
      n_fail++;
      $display("FAIL %s_hold f=%0d: got v=%b r=%h z=%b want v=0 r=%h",
               tag, f, out_valid, result, zero, exp);
    end
  endtask

  task automatic test_vectors;
    run_one(F_ADD, 32'hFFFF_FFFF, 32'h1, 0, "add_wrap");
    run_one(F_SLT, 32'hFFFF_FFFE, 32'h1, 0, "slt_neg");
    run_one(F_SLT, 32'h1, 32'hFFFF_FFFE, 0, "slt_pos");
    run_one(F_SUB, 32'd5, 32'd5, 0, "sub_zero");
    run_one(F_SUB, 32'd0, 32'd1, 0, "sub_wrap");
    run_one(F_SLL, 32'h0, 32'h3, 31, "sll_31");
    run_one(F_SLL, 32'h0, 32'h3, 0, "sll_0");
  endtask

  task automatic test_random_ops;
    logic [5:0] ops [8] = '{F_AND, F_OR, F_ADD, F_SUB,
                            F_SLT, F_SLL, F_MFHI, F_MFLO};
    logic [5:0] f;
    logic [W-1:0] x, y;
    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 8);
      if (k == 8) begin
        do f = 6'($urandom_range(0, 63));
        while (is_known(f));
      end else begin
        f = ops[k];
      end
      x = $urandom;
      y = ($urandom_range(0, 4) == 0) ? x : $urandom;
      run_one(f, x, y, $urandom_range(0, 31), "rand_op");
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0] ops [6] = '{F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SLL};
    logic [W-1:0] prev;
    bit have = 1'b0;
    prev = '0;
    for (int i = 0; i < 20; i++) begin
      int s;
      @(negedge clk);
      if (have) begin
        n_checks++;
        if (out_valid !== 1'b1 || result !== prev) begin
          n_fail++;
          $display("FAIL b2b[%0d]: got v=%b r=%h want v=1 r=%h",
                   i, out_valid, result, prev);
        end
      end
      s = $urandom_range(0, 31);
      funct = ops[$urandom_range(0, 5)];
      a = $urandom; b = $urandom; shamt = SW'(s);
      in_valid = 1'b1;
      prev = ref_op(funct, a, b, s);
      have = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || result !== prev) begin
      n_fail++;
      $display("FAIL b2b_last: got v=%b r=%h want v=1 r=%h",
               out_valid, result, prev);
    end
  endtask

  // Starts at a negedge right after acceptance; returns at the
  // first negedge with busy low. Pokes an ADD in mid-operation,
  // which must be refused.
  task automatic count_busy(input string tag);
    int cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      n_checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_busy cyc%0d: got rdy=%b v=%b want 0 0",
                 tag, cnt, in_ready, out_valid);
      end
      funct = F_ADD;
      in_valid = (cnt == 5);
      cnt++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++;
    if (cnt != W || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_len: got %0d cycles rdy=%b v=%b want %0d 1 0",
               tag, cnt, in_ready, out_valid, W);
    end
  endtask

  task automatic check_hilo(input string tag);
    run_one(F_MFHI, $urandom, $urandom, 0, {tag, "_hi"});
    run_one(F_MFLO, $urandom, $urandom, 0, {tag, "_lo"});
  endtask

  task automatic test_multu(input logic [W-1:0] x,
                            input logic [W-1:0] y);
    logic [2*W-1:0] p;
    p = 64'(x) * 64'(y);
    issue(F_MULTU, x, y, 0);
    @(negedge clk);
    count_busy("multu");
    m_hi = p[2*W-1:W];
    m_lo = p[W-1:0];
    check_hilo("multu");
  endtask

  task automatic test_multu_back_to_back;
    logic [W-1:0] x2, y2;
    logic [2*W-1:0] p;
    issue(F_MULTU, $urandom, $urandom, 0);
    @(negedge clk);
    count_busy("mb2b_first");
    x2 = $urandom; y2 = $urandom;
    p = 64'(x2) * 64'(y2);
    funct = F_MULTU; a = x2; b = y2;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL mb2b_start: got busy=%b want 1", busy);
    end
    count_busy("mb2b_second");
    m_hi = p[2*W-1:W];
    m_lo = p[W-1:0];
    check_hilo("mb2b");
  endtask

  task automatic test_mul_reset;
    issue(F_MULTU, $urandom | 32'h1, $urandom | 32'h1, 0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, in_ready, out_valid, zero} !== 4'b0101 ||
        result !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got flags=%b r=%h want 0101 0",
               {busy, in_ready, out_valid, zero}, result);
    end
    m_hi = '0;
    m_lo = '0;
    repeat (40) @(negedge clk);
    check_hilo("post_reset");
  endtask

`ifdef SEQ_ALU_DIVU_EN
  task automatic test_divu(input logic [W-1:0] x,
                           input logic [W-1:0] y);
    issue(F_DIVU, x, y, 0);
    @(negedge clk);
    count_busy("divu");
    m_lo = (y == 0) ? '1 : x / y;
    m_hi = (y == 0) ? x : x % y;
    check_hilo("divu");
  endtask
`endif

  task automatic test_funct27;
`ifdef SEQ_ALU_DIVU_EN
    test_divu(32'd100, 32'd7);
    test_divu(32'd9, 32'd0);
    for (int i = 0; i < 3; i++)
      test_divu($urandom, $urandom >> $urandom_range(0, 31));
`else
    run_one(F_DIVU, 32'd100, 32'd7, 0, "f27_unknown");
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL f27_busy: got %b want 0", busy);
    end
`endif
  endtask

  task automatic test_width16;
    int cnt = 0;
    issue16(F_ADD, 16'hFFFF, 16'h1, 0);
    @(negedge clk);
    n_checks++;
    if (out_valid16 !== 1'b1 || result16 !== 16'h0 ||
        zero16 !== 1'b1) begin
      n_fail++;
      $display("FAIL w16_add: got v=%b r=%h z=%b want 1 0000 1",
               out_valid16, result16, zero16);
    end
    issue16(F_SLL, 16'h0, 16'h3, 15);
    @(negedge clk);
    n_checks++;
    if (result16 !== 16'h8000 || zero16 !== 1'b0) begin
      n_fail++;
      $display("FAIL w16_sll: got r=%h z=%b want 8000 0",
               result16, zero16);
    end
    issue16(F_MULTU, 16'hFFFF, 16'hFFFF, 0);
    @(negedge clk);
    while (busy16 === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    n_checks++;
    if (cnt != 16) begin
      n_fail++;
      $display("FAIL w16_mul_len: got %0d want 16", cnt);
    end
    issue16(F_MFHI, 16'h0, 16'h0, 0);
    @(negedge clk);
    n_checks++;
    if (result16 !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL w16_mfhi: got %h want fffe", result16);
    end
    issue16(F_MFLO, 16'h0, 16'h0, 0);
    @(negedge clk);
    n_checks++;
    if (result16 !== 16'h0001) begin
      n_fail++;
      $display("FAIL w16_mflo: got %h want 0001", result16);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; funct = '0; shamt = '0; a = '0; b = '0;
    in_valid16 = 1'b0; funct16 = '0; shamt16 = '0;
    a16 = '0; b16 = '0;
    test_reset();
    check_hilo("reset");
    test_vectors();
    test_random_ops();
    test_back_to_back();
    test_multu(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    test_multu($urandom, $urandom);
    test_multu(32'h0, $urandom);
    test_multu_back_to_back();
    test_random_ops();
    test_mul_reset();
    test_funct27();
    test_width16();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu_unit.md
SEQ_ALU_UNIT -- requirements
Module: seq_alu_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width (8..64).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port clk  input  1  clock; single clock domain, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  unit accepts a request this cycle.
REQ-007 SHALL have port funct  input  6  function code: AND 36, OR 37, ADD 32, SUB 34, SLT 42, SLL 0, MULTU 25, MFHI 16, MFLO 18.
REQ-008 SHALL have port shamt  input  SHW  SLL shift amount.
REQ-009 SHALL have ports a, b  input  WIDTH  operands.
REQ-010 SHALL have port out_valid  output  1  result and zero valid this cycle.
REQ-011 SHALL have port result  output  WIDTH  registered result.
REQ-012 SHALL have port zero  output  1  registered flag, result == 0.
REQ-013 SHALL have port busy  output  1  multi-cycle operation in progress.

Function
REQ-014 A request SHALL be accepted when in_valid && in_ready; in_ready = !busy.
REQ-015 AND/OR/ADD/SUB/SLT/SLL/MFHI/MFLO SHALL assert out_valid exactly 1 cycle after acceptance, for one cycle.
REQ-016 ADD/SUB SHALL wrap modulo 2^WIDTH; no overflow trap.
REQ-017 SLT SHALL compare signed: result = 1 if $signed(a) < $signed(b), else 0.
REQ-018 SLL SHALL give result = b << shamt, zero-filled.
REQ-019 MULTU SHALL compute the unsigned 2*WIDTH product into HI (upper) and LO (lower).
REQ-020 MULTU SHALL use a shift-add FSM with states IDLE -> MUL; MUL lasts WIDTH cycles; then back to IDLE.
REQ-021 MULTU SHALL hold busy high from the cycle after acceptance through the last MUL cycle.
REQ-022 MULTU SHALL update HI/LO atomically on the final MUL cycle.
REQ-023 MULTU SHALL not assert out_valid.
REQ-024 MFHI/MFLO SHALL return the current HI/LO; they cannot issue during busy, so never return a partial product.
REQ-025 An unknown funct SHALL be accepted and SHALL give out_valid with result = 0, zero = 1.
REQ-026 result and zero SHALL hold their last values while out_valid is low.
REQ-027 A MULTU accepted on the cycle IDLE is re-entered SHALL start immediately; no bubble is required.

Reset
REQ-028 rst SHALL override all activity in the same cycle, including mid-MULTU; that multiply is abandoned.
REQ-029 After rst: state IDLE, busy 0, in_ready 1, out_valid 0, result 0, zero 1, HI 0, LO 0.

Configuration
REQ-030 With macro SEQ_ALU_DIVU_EN defined, funct 27 (DIVU) SHALL be supported.
REQ-031 DIVU SHALL use a restoring divider FSM state DIV of WIDTH cycles, giving LO = a/b and HI = a%b.
REQ-032 DIVU by zero SHALL give LO = all-ones, HI = a.
REQ-033 DIVU busy and out_valid rules SHALL match MULTU.
REQ-034 Without SEQ_ALU_DIVU_EN, funct 27 SHALL be treated as unknown (REQ-025), and no divider logic SHALL exist.

Structure
REQ-035 Package seq_alu_pkg SHALL hold the funct code localparams and the FSM state enum (IDLE, MUL, DIV).
REQ-036 Sub-module seq_alu_muldiv SHALL contain the iterative multiplier and optional divider, HI/LO, and the FSM.
REQ-037 The top level SHALL contain the combinational ops and the output register.

Verification
REQ-038 ADD a=0xFFFFFFFF, b=1 -> next cycle out_valid=1, result=0, zero=1.
REQ-039 SLT a=0xFFFFFFFE (-2), b=1 -> result=1; SUB 5-5 -> result=0, zero=1.
REQ-040 SLL b=0x00000003, shamt=31 -> result=0x80000000.
REQ-041 MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> busy 32 cycles, in_ready low; then MFHI -> 0xFFFFFFFE and MFLO -> 0x00000001.
REQ-042 rst at MUL cycle 10 -> next cycle busy=0, in_ready=1; MFHI -> 0, MFLO -> 0.
REQ-043 With SEQ_ALU_DIVU_EN: DIVU 100/7 -> LO=14, HI=2; DIVU 9/0 -> LO=0xFFFFFFFF, HI=9; with WIDTH=16, repeat REQ-038 scaled (0xFFFF+1 -> 0).
